data_mem_ctrl: RTL



---
 rtl/data_mem_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/data_mem_ctrl.sv
// Byte-addressed data memory for the multicycle CPU MEM stage.
// Byte/half/word access over a req/done handshake, with configurable latency and alignment checking.
module data_mem_ctrl #(
  parameter int ADDR_W     = 10,
  parameter int WAIT_CYC   = 1,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [1:0]  i_size,
  input  logic        i_sext,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_ready,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic        o_err
);
  // state  | meaning
  // S_IDLE | ready, accepts a request
  // S_WAIT | counting extra latency cycles
  // S_RESP | done pulse, result valid
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;

  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic [3:0] CNT_INIT = (WAIT_CYC == 0) ? 4'd0 : 4'(WAIT_CYC - 1);

  state_t            r_state, w_next;
  logic              r_we, r_sext, r_err;
  logic [1:0]        r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata, r_rdata;
  logic [3:0]        r_cnt;
  logic [7:0]        r_mem [DEPTH];

  logic              w_accept, w_enter_resp, w_err_in, w_store_en;
  logic              w_c_we, w_c_sext, w_c_err;
  logic [1:0]        w_c_size;
  logic [ADDR_W-1:0] w_c_addr;
  logic [31:0]       w_c_wdata, w_field, w_load;
  logic [2:0]        w_nbytes;
  logic [3:0]        w_wen;
  logic [7:0]        w_wbyte [4];
  logic              w_unused;

  assign w_unused     = ^i_addr[31:ADDR_W];
  assign w_accept     = (r_state == S_IDLE) && i_req;
  assign w_err_in     = (i_size == 2'b11) || ((i_size == 2'b01) && i_addr[0]) ||
                        ((i_size == 2'b00) && (i_addr[1:0] != 2'b00));
  assign w_enter_resp = (w_next == S_RESP) && (r_state != S_RESP);
  assign w_store_en   = w_enter_resp && w_c_we && !w_c_err;

  // With zero wait cycles RESP is entered on the accept edge, before the latches hold the request.
  always_comb begin
    if (r_state == S_IDLE) begin
      w_c_we    = i_we;
      w_c_sext  = i_sext;
      w_c_err   = w_err_in;
      w_c_size  = i_size;
      w_c_addr  = i_addr[ADDR_W-1:0];
      w_c_wdata = i_wdata;
    end else begin
      w_c_we    = r_we;
      w_c_sext  = r_sext;
      w_c_err   = r_err;
      w_c_size  = r_size;
      w_c_addr  = r_addr;
      w_c_wdata = r_wdata;
    end
  end

  always_comb begin
    case (w_c_size)
      2'b00:   w_nbytes = 3'd4;
      2'b01:   w_nbytes = 3'd2;
      default: w_nbytes = 3'd1;
    endcase
  end

  // Lane k of the access is byte address A+k; idx selects which byte of the field it carries.
  always_comb begin
    int idx;
    idx     = 0;
    w_field = '0;
    w_wen   = '0;
    for (int k = 0; k < 4; k++) begin
      w_wbyte[k] = 8'h00;
      if (k < int'(w_nbytes)) begin
        idx = BIG_ENDIAN ? (int'(w_nbytes) - 1 - k) : k;
        w_field[8*idx +: 8] = r_mem[w_c_addr + ADDR_W'(k)];
        w_wbyte[k] = w_c_wdata[8*idx +: 8];
        w_wen[k]   = w_store_en;
      end
    end
  end

  always_comb begin
    case (w_c_size)
      2'b00:   w_load = w_field;
      2'b01:   w_load = {{16{w_c_sext & w_field[15]}}, w_field[15:0]};
      default: w_load = {{24{w_c_sext & w_field[7]}}, w_field[7:0]};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_req) w_next = (WAIT_CYC == 0) ? S_RESP : S_WAIT;
      S_WAIT:  if (r_cnt == 4'd0) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_ready = (r_state == S_IDLE);
    o_done  = (r_state == S_RESP);
    o_err   = (r_state == S_RESP) && r_err;
    o_rdata = r_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_sext  <= 1'b0;
      r_err   <= 1'b0;
      r_size  <= 2'b00;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_cnt   <= 4'd0;
    end else begin
      if (w_accept) begin
        r_we    <= i_we;
        r_sext  <= i_sext;
        r_err   <= w_err_in;
        r_size  <= i_size;
        r_addr  <= i_addr[ADDR_W-1:0];
        r_wdata <= i_wdata;
        r_cnt   <= CNT_INIT;
      end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_enter_resp && !w_c_we) r_rdata <= w_c_err ? 32'h0 : w_load;
    end
  end

  // Not reset: contents are undefined until written.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++)
      if (w_wen[k]) r_mem[w_c_addr + ADDR_W'(k)] <= w_wbyte[k];
  end
endmodule
